// File: rtl/scnn_top.sv
// Sequential spiking-convolution engine: one MAC time-shared over ROW*COL neuron potentials.
// Optional per-neuron timestep leak enabled by defining SCNN_LEAK_EN.
module scnn_top #(
  parameter int unsigned FILTER_WIDTH = 8,
  parameter int unsigned IFMAP_SIZE   = 9,
  parameter int unsigned OUTPUT_WIDTH = 12,
  parameter int unsigned THRESHOLD    = 16,
  parameter int unsigned ROW          = 2,
  parameter int unsigned COL          = 3,
  localparam int unsigned PACKET_WIDTH = 3*FILTER_WIDTH+9
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [PACKET_WIDTH-1:0] packet_in_data,
  input  logic                    packet_in_valid,
  output logic                    packet_in_ready,
  output logic [PACKET_WIDTH-1:0] packet_out_data,
  output logic                    packet_out_valid,
  input  logic                    packet_out_ready
);

  localparam int unsigned NUM_NEURONS = ROW*COL;
  localparam int unsigned SUM_W       = FILTER_WIDTH+4;
  localparam int unsigned SAT_W       = OUTPUT_WIDTH+1;
  localparam int unsigned K_W         = 4;
  localparam int unsigned N_W         = 3;
  localparam int unsigned POT_FIELD_W = PACKET_WIDTH-16;
  localparam logic [OUTPUT_WIDTH-1:0] POT_MAX = '1;
  localparam logic [OUTPUT_WIDTH-1:0] THR     = OUTPUT_WIDTH'(THRESHOLD);

  typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_UPDATE, ST_SEND} state_e;

  state_e                    state_q, state_d;
  logic [FILTER_WIDTH-1:0]   w_q   [IFMAP_SIZE];
  logic [FILTER_WIDTH-1:0]   w_d   [IFMAP_SIZE];
  logic [OUTPUT_WIDTH-1:0]   pot_q [NUM_NEURONS];
  logic [OUTPUT_WIDTH-1:0]   pot_d [NUM_NEURONS];
  logic [K_W-1:0]            k_q, k_d;
  logic [SUM_W-1:0]          acc_q, acc_d;
  logic [IFMAP_SIZE-1:0]     spk_q, spk_d;
  logic [N_W-1:0]            n_q, n_d;
  logic                      ts_q, ts_d;
  logic                      out_valid_q, out_valid_d;
  logic [PACKET_WIDTH-1:0]   out_data_q, out_data_d;
`ifdef SCNN_LEAK_EN
  logic                      last_ts_q [NUM_NEURONS];
  logic                      last_ts_d [NUM_NEURONS];
  logic                      leak_q, leak_d;
`endif

  // Header decode
  logic                    hdr_ts;
  logic [1:0]              hdr_type;
  logic [1:0]              hdr_row;
  logic [N_W-1:0]          hdr_n;
  logic [K_W-1:0]          row_base;
  logic                    unused_hdr;

  assign hdr_ts     = packet_in_data[0];
  assign hdr_type   = packet_in_data[2:1];
  assign hdr_row    = packet_in_data[4:3];
  assign hdr_n      = packet_in_data[7:5];
  assign row_base   = K_W'(3*hdr_row);
  assign unused_hdr = packet_in_data[8];

  // Saturating potential update for the latched neuron
  logic [OUTPUT_WIDTH-1:0] pot_base;
  logic [SAT_W-1:0]        pot_sum;
  logic [OUTPUT_WIDTH-1:0] pot_v;
  logic                    fire;
  logic [OUTPUT_WIDTH-1:0] new_pot;

`ifdef SCNN_LEAK_EN
  assign pot_base = leak_q ? (pot_q[n_q] >> 1) : pot_q[n_q];
`else
  assign pot_base = pot_q[n_q];
`endif
  assign pot_sum = SAT_W'(pot_base) + SAT_W'(acc_q);
  assign pot_v   = (pot_sum > SAT_W'(POT_MAX)) ? POT_MAX : pot_sum[OUTPUT_WIDTH-1:0];
  assign fire    = (pot_v >= THR);
  assign new_pot = fire ? (pot_v - THR) : pot_v;

  always_comb begin
    state_d     = state_q;
    w_d         = w_q;
    pot_d       = pot_q;
    k_d         = k_q;
    acc_d       = acc_q;
    spk_d       = spk_q;
    n_d         = n_q;
    ts_d        = ts_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
`ifdef SCNN_LEAK_EN
    last_ts_d   = last_ts_q;
    leak_d      = leak_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (packet_in_valid) begin
          if (hdr_type == 2'b00 && hdr_row != 2'd3) begin
            for (int j = 0; j < 3; j++) begin
              w_d[row_base + K_W'(j)] = packet_in_data[9+FILTER_WIDTH*j +: FILTER_WIDTH];
            end
          end else if (hdr_type == 2'b01 && 32'(hdr_n) < NUM_NEURONS) begin
            spk_d   = packet_in_data[9 +: IFMAP_SIZE];
            n_d     = hdr_n;
            ts_d    = hdr_ts;
            acc_d   = '0;
            k_d     = '0;
            state_d = ST_MAC;
`ifdef SCNN_LEAK_EN
            leak_d  = (hdr_ts != last_ts_q[hdr_n]);
`endif
          end
        end
      end
      ST_MAC: begin
        acc_d = acc_q + (spk_q[k_q] ? SUM_W'(w_q[k_q]) : '0);
        if (k_q == K_W'(IFMAP_SIZE-1)) begin
          k_d     = '0;
          state_d = ST_UPDATE;
        end else begin
          k_d = k_q + K_W'(1);
        end
      end
      ST_UPDATE: begin
        pot_d[n_q]  = new_pot;
`ifdef SCNN_LEAK_EN
        last_ts_d[n_q] = ts_q;
`endif
        out_data_d  = {POT_FIELD_W'(new_pot), 8'h00, n_q, fire, 3'b111, ts_q};
        out_valid_d = 1'b1;
        state_d     = ST_SEND;
      end
      ST_SEND: begin
        if (packet_out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      for (int i = 0; i < IFMAP_SIZE; i++) w_q[i] <= '0;
      for (int i = 0; i < NUM_NEURONS; i++) pot_q[i] <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      spk_q       <= '0;
      n_q         <= '0;
      ts_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
`ifdef SCNN_LEAK_EN
      for (int i = 0; i < NUM_NEURONS; i++) last_ts_q[i] <= 1'b0;
      leak_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      w_q         <= w_d;
      pot_q       <= pot_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      spk_q       <= spk_d;
      n_q         <= n_d;
      ts_q        <= ts_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
`ifdef SCNN_LEAK_EN
      last_ts_q   <= last_ts_d;
      leak_q      <= leak_d;
`endif
    end
  end

  assign packet_in_ready  = (state_q == ST_IDLE);
  assign packet_out_valid = out_valid_q;
  assign packet_out_data  = out_data_q;

endmodule

// File: tb/tb_scnn_top.sv
// Directed scoreboard bench for scnn_top: filters, patches, saturation, backpressure, drops, mid-MAC reset.
module tb_scnn_top;
  localparam int unsigned PW = 33;

  logic          clk = 1'b0;
  logic          reset;
  logic [PW-1:0] packet_in_data;
  logic          packet_in_valid;
  logic          packet_in_ready;
  logic [PW-1:0] packet_out_data;
  logic          packet_out_valid;
  logic          packet_out_ready;

  int vectors     = 0;
  int miscompares = 0;

  logic [PW-1:0] sb_q[$];
  int m_w   [9];
  int m_pot [8];
  bit m_ts  [8];

  scnn_top dut (
    .clk              (clk),
    .reset            (reset),
    .packet_in_data   (packet_in_data),
    .packet_in_valid  (packet_in_valid),
    .packet_in_ready  (packet_in_ready),
    .packet_out_data  (packet_out_data),
    .packet_out_valid (packet_out_valid),
    .packet_out_ready (packet_out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] fpkt(input int r, input int a, input int b, input int c);
    return {8'(c), 8'(b), 8'(a), 1'b0, 3'b000, 2'(r), 2'b00, 1'b0};
  endfunction

  function automatic logic [PW-1:0] ppkt(input int ts, input int sp, input int n);
    return {15'b0, 9'(sp), 1'b0, 3'(n), 2'b00, 2'b01, 1'(ts)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 9; i++) m_w[i] = 0;
    for (int i = 0; i < 8; i++) begin m_pot[i] = 0; m_ts[i] = 1'b0; end
  endtask

  task automatic model_filter(input int r, input int a, input int b, input int c);
    if (r < 3) begin m_w[3*r] = a; m_w[3*r+1] = b; m_w[3*r+2] = c; end
  endtask

  task automatic model_patch(input int ts, input int sp, input int n);
    int p, sum, v;
    bit f;
    p = m_pot[n];
`ifdef SCNN_LEAK_EN
    if (m_ts[n] != 1'(ts)) p = p / 2;
    m_ts[n] = 1'(ts);
`endif
    sum = 0;
    for (int k = 0; k < 9; k++) if (((sp >> k) & 1) == 1) sum += m_w[k];
    v = p + sum;
    if (v > 4095) v = 4095;
    f = (v >= 16);
    if (f) v -= 16;
    m_pot[n] = v;
    sb_q.push_back({5'b0, 12'(v), 8'h00, 3'(n), f, 3'b111, 1'(ts)});
  endtask

  task automatic send(input logic [PW-1:0] pkt);
    for (int i = 0; i < 20 && !packet_in_ready; i++) @(negedge clk);
    check("in_ready_before_send", {32'b0, packet_in_ready}, 33'd1);
    packet_in_data  = pkt;
    packet_in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    packet_in_valid = 1'b0;
  endtask

  task automatic load_filter(input int r, input int a, input int b, input int c);
    model_filter(r, a, b, c);
    send(fpkt(r, a, b, c));
    check("in_ready_after_filter", {32'b0, packet_in_ready}, 33'd1);
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (packet_out_valid) begin lat = c; break; end
    end
    check("out_latency", 33'(lat), 33'd10);
  endtask

  task automatic run_patch(input int ts, input int sp, input int n);
    int lat;
    logic [PW-1:0] exp;
    model_patch(ts, sp, n);
    send(ppkt(ts, sp, n));
    check("in_ready_busy", {32'b0, packet_in_ready}, 33'd0);
    wait_out(lat);
    exp = sb_q.pop_front();
    check("out_data", packet_out_data, exp);
    @(negedge clk);
    check("out_valid_after_hs", {32'b0, packet_out_valid}, 33'd0);
    check("in_ready_after_hs", {32'b0, packet_in_ready}, 33'd1);
  endtask

  task automatic quiet_window(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (packet_out_valid || !packet_in_ready) seen++;
    end
    check(tag, 33'(seen), 33'd0);
  endtask

  initial begin
    int lat;
    logic [PW-1:0] exp;
    reset            = 1'b1;
    packet_in_data   = '0;
    packet_in_valid  = 1'b0;
    packet_out_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    check("reset_in_ready", {32'b0, packet_in_ready}, 33'd1);
    check("reset_out_valid", {32'b0, packet_out_valid}, 33'd0);
    check("reset_out_data", packet_out_data, 33'd0);

    // zero weights: no fire, zero residue
    run_patch(0, 9'h1FF, 0);

    // weights 1..9, accumulate on neuron 2
    load_filter(0, 1, 2, 3);
    load_filter(1, 4, 5, 6);
    load_filter(2, 7, 8, 9);
    run_patch(0, 9'h001, 2);
    run_patch(0, 9'h1FF, 2);

    // all-255 weights, saturation on neuron 5
    load_filter(0, 255, 255, 255);
    load_filter(1, 255, 255, 255);
    load_filter(2, 255, 255, 255);
    run_patch(0, 9'h1FF, 5);
    run_patch(0, 9'h1FF, 5);

    // backpressure: sink stalls for 5 cycles
    packet_out_ready = 1'b0;
    model_patch(0, 9'h001, 1);
    send(ppkt(0, 9'h001, 1));
    wait_out(lat);
    exp = sb_q.pop_front();
    check("stall_first_data", packet_out_data, exp);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("stall_valid", {32'b0, packet_out_valid}, 33'd1);
      check("stall_data", packet_out_data, exp);
      check("stall_in_ready", {32'b0, packet_in_ready}, 33'd0);
    end
    packet_out_ready = 1'b1;
    @(negedge clk);
    check("stall_release_valid", {32'b0, packet_out_valid}, 33'd0);
    check("stall_release_in_ready", {32'b0, packet_in_ready}, 33'd1);

    // dropped packets: n out of range, type 1x, filter row 3
    send(ppkt(0, 9'h1FF, 6));
    send({15'b0, 9'h1FF, 1'b0, 3'd0, 2'b00, 2'b10, 1'b0});
    send(fpkt(3, 1, 1, 1));
    quiet_window("drop_no_output", 12);
    run_patch(0, 9'h001, 5);

    // reset in the middle of MAC aborts with no output
    load_filter(0, 1, 2, 3);
    load_filter(1, 4, 5, 6);
    load_filter(2, 7, 8, 9);
    send(ppkt(0, 9'h1FF, 3));
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check("midreset_out_data", packet_out_data, 33'd0);
    quiet_window("midreset_no_output", 14);
    load_filter(0, 1, 2, 3);
    load_filter(1, 4, 5, 6);
    load_filter(2, 7, 8, 9);
    run_patch(0, 9'h1FF, 3);

    // timestep toggle with no spikes (halves the residue only when leak is built in)
    run_patch(1, 9'h000, 3);
    run_patch(1, 9'h002, 3);

    check("scoreboard_empty", 33'(sb_q.size()), 33'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
